// File: rtl/rect_fill_issuer_pkg.sv
// Shared constants for the rectangle fill issuer: instruction geometry,
// plot field positions, screen bounds and a bound-clipping helper.
package rect_fill_issuer_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int OPCODE_WIDTH      = 4;

  localparam int OPCODE_PLOT = 1;

  localparam int PLOT_X_LSB      = 0;
  localparam int PLOT_X_MSB      = 7;
  localparam int PLOT_Y_LSB      = 8;
  localparam int PLOT_Y_MSB      = 14;
  localparam int PLOT_COLOUR_LSB = 15;
  localparam int PLOT_COLOUR_MSB = 17;
  localparam int PLOT_BIT        = 18;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Exclusive end coordinate of a span, clipped to the screen limit.
  // Nine bits hold start+len for any 8-bit start and length, so no wrap.
  function automatic logic [8:0] clip_end(input logic [8:0] start,
                                          input logic [8:0] len,
                                          input logic [8:0] limit);
    logic [8:0] sum;
    sum = start + len;
    return (sum < limit) ? sum : limit;
  endfunction

endpackage

// File: rtl/rect_fill_issuer_if.sv
// Start/finished instruction handshake between the issuer and the datapath.
interface rect_fill_issuer_if
  import rect_fill_issuer_pkg::*;
#(
  parameter int IW = INSTRUCTION_WIDTH
) ();

  logic          start;
  logic [IW-1:0] instruction;
  logic          finished;

  modport master (output start, output instruction, input finished);
  modport slave  (input start, input instruction, output finished);

endinterface

// File: rtl/rect_fill_issuer.sv
// Filled-rectangle issuer: walks the clipped rectangle in raster order,
// handing one plot instruction per pixel to the datapath, then a plot-off.
module rect_fill_issuer
  import rect_fill_issuer_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = rect_fill_issuer_pkg::INSTRUCTION_WIDTH,
  parameter int OPCODE_WIDTH      = rect_fill_issuer_pkg::OPCODE_WIDTH,
  parameter int SCREEN_W          = rect_fill_issuer_pkg::SCREEN_W,
  parameter int SCREEN_H          = rect_fill_issuer_pkg::SCREEN_H
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      req,
  input  logic [7:0]                req_x0,
  input  logic [6:0]                req_y0,
  input  logic [7:0]                req_w,
  input  logic [6:0]                req_h,
  input  logic [2:0]                req_colour,
  output logic                      busy,
  output logic                      done,
  rect_fill_issuer_if.master        dp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OFF_ISSUE,
    ST_OFF_WAIT
  } state_e;

  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [8:0] Y_LIMIT = 9'(SCREEN_H);

  state_e                       state_q,  state_d;
  logic                         busy_q,   busy_d;
  logic                         done_q,   done_d;
  logic                         start_q,  start_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q,  instr_d;
  logic [7:0]                   x_q,      x_d;
  logic [6:0]                   y_q,      y_d;
  logic [7:0]                   x0_q,     x0_d;
  logic [8:0]                   x_end_q,  x_end_d;
  logic [8:0]                   y_end_q,  y_end_d;
  logic [2:0]                   colour_q, colour_d;

  // Clipped bounds of the incoming request, used only on the accept edge.
  logic [8:0] acc_x_end;
  logic [8:0] acc_y_end;
  logic       req_empty;

  assign acc_x_end = clip_end({1'b0, req_x0}, {1'b0, req_w}, X_LIMIT);
  assign acc_y_end = clip_end({2'b0, req_y0}, {2'b0, req_h}, Y_LIMIT);
  assign req_empty = ({1'b0, req_x0} >= acc_x_end) ||
                     ({2'b0, req_y0} >= acc_y_end);

  // Raster cursor stepping: x fastest, wrap to the left column per row.
  logic       row_last;
  logic       last_pixel;
  logic [7:0] x_next;
  logic [6:0] y_next;

  assign row_last   = ({1'b0, x_q} + 9'd1) >= x_end_q;
  assign last_pixel = row_last && (({2'b0, y_q} + 9'd1) >= y_end_q);
  assign x_next     = row_last ? x0_q : x_q + 8'd1;
  assign y_next     = row_last ? y_q + 7'd1 : y_q;

  function automatic logic [INSTRUCTION_WIDTH-1:0] pack_plot(
    input logic [7:0] x,
    input logic [6:0] y,
    input logic [2:0] colour,
    input logic       plot
  );
    logic [INSTRUCTION_WIDTH-1:0] word;
    word = '0;
    word[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH]    = OPCODE_WIDTH'(OPCODE_PLOT);
    word[PLOT_X_MSB:PLOT_X_LSB]                  = x;
    word[PLOT_Y_MSB:PLOT_Y_LSB]                  = y;
    word[PLOT_COLOUR_MSB:PLOT_COLOUR_LSB]        = colour;
    word[PLOT_BIT]                               = plot;
    return word;
  endfunction

  // Next-state and registered-output logic for the issue sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case, otherwise an
    // unassigned path turns it into a latch.
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    start_d  = start_q;
    instr_d  = instr_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    x_end_d  = x_end_q;
    y_end_d  = y_end_q;
    colour_d = colour_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (req_empty) begin
            // Nothing on screen: finish immediately, datapath untouched.
            done_d = 1'b1;
          end else begin
            busy_d   = 1'b1;
            start_d  = 1'b1;
            x_d      = req_x0;
            y_d      = req_y0;
            x0_d     = req_x0;
            x_end_d  = acc_x_end;
            y_end_d  = acc_y_end;
            colour_d = req_colour;
            instr_d  = pack_plot(req_x0, req_y0, req_colour, 1'b1);
            state_d  = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // Drop start on the accepting edge so one instruction is taken once.
        if (dp.finished) begin
          start_d = 1'b0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (dp.finished) begin
          start_d = 1'b1;
          if (last_pixel) begin
            instr_d = pack_plot(x_q, y_q, colour_q, 1'b0);
            state_d = ST_OFF_ISSUE;
          end else begin
            x_d     = x_next;
            y_d     = y_next;
            instr_d = pack_plot(x_next, y_next, colour_q, 1'b1);
            state_d = ST_ISSUE;
          end
        end
      end

      ST_OFF_ISSUE: begin
        if (dp.finished) begin
          start_d = 1'b0;
          state_d = ST_OFF_WAIT;
        end
      end

      ST_OFF_WAIT: begin
        if (dp.finished) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      instr_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      colour_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      start_q  <= start_d;
      instr_q  <= instr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      x_end_q  <= x_end_d;
      y_end_q  <= y_end_d;
      colour_q <= colour_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign dp.start       = start_q;
  assign dp.instruction = instr_q;

endmodule

// File: tb/tb_rect_fill_issuer.sv
// Bench for rect_fill_issuer: behavioural datapath responder, raster-order
// reference model feeding a scoreboard, and a decoupled accept monitor.
module tb_rect_fill_issuer;
  import rect_fill_issuer_pkg::*;

  localparam int IW = INSTRUCTION_WIDTH;
  localparam int OW = OPCODE_WIDTH;

  logic       clock = 1'b0;
  logic       resetn;
  logic       req;
  logic [7:0] req_x0;
  logic [6:0] req_y0;
  logic [7:0] req_w;
  logic [6:0] req_h;
  logic [2:0] req_colour;
  logic       busy;
  logic       done;

  rect_fill_issuer_if #(.IW(IW)) dp ();

  rect_fill_issuer #(
    .INSTRUCTION_WIDTH(IW),
    .OPCODE_WIDTH(OW),
    .SCREEN_W(160),
    .SCREEN_H(120)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .req(req),
    .req_x0(req_x0),
    .req_y0(req_y0),
    .req_w(req_w),
    .req_h(req_h),
    .req_colour(req_colour),
    .busy(busy),
    .done(done),
    .dp(dp)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and event counters shared between stimulus and monitors.
  logic [IW-1:0] exp_q[$];
  int accept_cnt  = 0;
  int done_cnt    = 0;
  int hold_cycles = 2;

  // Expected instruction word, built from the documented field layout.
  function automatic logic [IW-1:0] expect_word(input int x, input int y,
                                                input int c, input int plot);
    logic [IW-1:0] w;
    w = IW'(OPCODE_PLOT) << (IW - OW);
    w = w | IW'(x) | (IW'(y) << 8) | (IW'(c) << 15) | (IW'(plot) << 18);
    return w;
  endfunction

  // Reference model: every on-screen pixel in raster order, then plot-off.
  task automatic model_rect(input int x0, input int y0, input int w, input int h,
                            input int c, output int n);
    int lx = 0;
    int ly = 0;
    n = 0;
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        if (x < 160 && y < 120) begin
          exp_q.push_back(expect_word(x, y, c, 1));
          n++;
          lx = x;
          ly = y;
        end
    if (n > 0) begin
      exp_q.push_back(expect_word(lx, ly, c, 0));
      n++;
    end
  endtask

  // Datapath responder: after each accept, finished drops for hold_cycles.
  initial begin
    int h;
    dp.finished = 1'b1;
    forever begin
      @(negedge clock);
      if (resetn === 1'b1 && dp.start === 1'b1 && dp.finished === 1'b1) begin
        h = hold_cycles;
        @(posedge clock);
        #1 dp.finished = 1'b0;
        repeat (h) @(posedge clock);
        #1 dp.finished = 1'b1;
      end
    end
  end

  // Accept monitor: pops the scoreboard on every start&finished.
  always @(negedge clock) begin
    if (resetn === 1'b1 && dp.start === 1'b1 && dp.finished === 1'b1) begin
      accept_cnt++;
      check("sb_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("instruction", 64'(dp.instruction), 64'(exp_q.pop_front()));
    end
  end

  // Done monitor: counts pulses and insists each lasts one cycle.
  logic prev_done = 1'b0;
  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_cnt++;
      check("done_single_cycle", 64'(prev_done), 64'd0);
    end
    prev_done = done;
  end

  // Stall monitor: while busy and finished low, start/instruction hold.
  logic          prev_hold = 1'b0;
  logic          prev_start;
  logic [IW-1:0] prev_instr;
  always @(negedge clock) begin
    if (prev_hold && resetn === 1'b1) begin
      check("stall_start", 64'(dp.start), 64'(prev_start));
      check("stall_instruction", 64'(dp.instruction), 64'(prev_instr));
    end
    prev_hold  = (resetn === 1'b1) && (busy === 1'b1) && (dp.finished === 1'b0);
    prev_start = dp.start;
    prev_instr = dp.instruction;
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 3000) check("timeout_idle", 64'(busy), 64'd0);
  endtask

  // One-cycle request strobe: accept edge is the posedge in between.
  task automatic send_req(input int x0, input int y0, input int w, input int h, input int c);
    @(negedge clock);
    req        = 1'b1;
    req_x0     = 8'(x0);
    req_y0     = 7'(y0);
    req_w      = 8'(w);
    req_h      = 7'(h);
    req_colour = 3'(c);
    @(negedge clock);
    req = 1'b0;
  endtask

  task automatic wait_accepts(input int target);
    int k = 0;
    while (accept_cnt < target && k < 3000) begin
      @(posedge clock);
      k++;
    end
    if (k >= 3000) check("timeout_accepts", 64'(accept_cnt), 64'(target));
  endtask

  task automatic finish_req(input string tag, input int a0, input int d0, input int n);
    int k = 0;
    while (done_cnt <= d0 && k < 3000) begin
      @(posedge clock);
      k++;
    end
    if (k >= 3000) check({tag, "_timeout_done"}, 64'(done_cnt), 64'(d0 + 1));
    repeat (3) @(negedge clock);
    check({tag, "_accepts"}, 64'(accept_cnt - a0), 64'(n));
    check({tag, "_dones"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  task automatic run_req(input string tag, input int x0, input int y0, input int w,
                         input int h, input int c);
    int n, a0, d0;
    wait_idle();
    a0 = accept_cnt;
    d0 = done_cnt;
    model_rect(x0, y0, w, h, c, n);
    send_req(x0, y0, w, h, c);
    finish_req(tag, a0, d0, n);
  endtask

  task automatic run_empty(input string tag, input int x0, input int y0, input int w,
                           input int h);
    int n, a0;
    wait_idle();
    a0 = accept_cnt;
    model_rect(x0, y0, w, h, 1, n);
    check({tag, "_model_empty"}, 64'(n), 64'd0);
    @(negedge clock);
    req = 1'b1; req_x0 = 8'(x0); req_y0 = 7'(y0); req_w = 8'(w); req_h = 7'(h);
    req_colour = 3'd1;
    @(posedge clock);
    #1;
    check({tag, "_done_after_accept"}, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_start"}, 64'(dp.start), 64'd0);
    @(negedge clock);
    req = 1'b0;
    @(posedge clock);
    #1;
    check({tag, "_done_dropped"}, 64'(done), 64'd0);
    repeat (3) @(negedge clock);
    check({tag, "_no_accepts"}, 64'(accept_cnt - a0), 64'd0);
  endtask

  initial begin
    int a0, d0, n;
    logic [IW-1:0] w1;
    resetn = 1'b0;
    req = 1'b0; req_x0 = '0; req_y0 = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_start", 64'(dp.start), 64'd0);
    check("rst_instruction", 64'(dp.instruction), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    resetn = 1'b1;

    run_req("rect2x2", 10, 20, 2, 2, 5);
    run_req("clip", 158, 118, 5, 4, 3);
    run_empty("empty_w0", 10, 10, 0, 3);
    run_empty("empty_x200", 200, 10, 10, 3);
    run_empty("empty_h0", 5, 5, 4, 0);

    // Long stall in the middle of a 3x2 rectangle.
    wait_idle();
    a0 = accept_cnt; d0 = done_cnt;
    model_rect(40, 50, 3, 2, 7, n);
    send_req(40, 50, 3, 2, 7);
    wait_accepts(a0 + 2);
    hold_cycles = 50;
    wait_accepts(a0 + 3);
    hold_cycles = 2;
    repeat (40) @(posedge clock);
    check("stall_no_extra_accept", 64'(accept_cnt - a0), 64'd3);
    finish_req("stall", a0, d0, n);

    // Request pulsed while busy must be dropped.
    wait_idle();
    a0 = accept_cnt; d0 = done_cnt;
    model_rect(60, 30, 3, 1, 4, n);
    send_req(60, 30, 3, 1, 4);
    repeat (3) @(negedge clock);
    check("busy_during_req", 64'(busy), 64'd1);
    req = 1'b1; req_x0 = 8'd0; req_y0 = 7'd0; req_w = 8'd5; req_h = 7'd5;
    @(negedge clock);
    req = 1'b0;
    finish_req("busy_req", a0, d0, n);

    // Reset during pixel 2 of a 4x4, then a 1x1 while finished is low.
    wait_idle();
    a0 = accept_cnt;
    model_rect(30, 40, 4, 4, 2, n);
    send_req(30, 40, 4, 4, 2);
    wait_accepts(a0 + 1);
    hold_cycles = 12;
    wait_accepts(a0 + 2);
    hold_cycles = 2;
    #3 resetn = 1'b0;
    #1;
    check("midrst_start", 64'(dp.start), 64'd0);
    check("midrst_instruction", 64'(dp.instruction), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    @(posedge clock);
    #1 resetn = 1'b1;
    a0 = accept_cnt; d0 = done_cnt;
    model_rect(7, 9, 1, 1, 6, n);
    w1 = expect_word(7, 9, 6, 1);
    send_req(7, 9, 1, 1, 6);
    check("postrst_finished_low", 64'(dp.finished), 64'd0);
    check("postrst_start_held", 64'(dp.start), 64'd1);
    begin
      int k = 0;
      while (dp.finished !== 1'b1 && k < 40) begin
        @(negedge clock);
        k++;
      end
      check("postrst_finished_returns", 64'(dp.finished), 64'd1);
    end
    check("postrst_still_presenting", 64'(dp.start), 64'd1);
    check("postrst_instruction", 64'(dp.instruction), 64'(w1));
    finish_req("postrst", a0, d0, n);

    // Randomised rectangles, some hanging off the screen edges.
    for (int i = 0; i < 16; i++) begin
      int x0 = int'($urandom_range(0, 170));
      int y0 = int'($urandom_range(0, 127));
      int w  = int'($urandom_range(1, 6));
      int h  = int'($urandom_range(1, 4));
      int c  = int'($urandom_range(0, 7));
      wait_idle();
      a0 = accept_cnt; d0 = done_cnt;
      model_rect(x0, y0, w, h, c, n);
      if (n == 0) begin
        run_empty("rand_empty", x0, y0, w, h);
      end else begin
        send_req(x0, y0, w, h, c);
        finish_req("rand", a0, d0, n);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
